// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-compare GCD datapath: loads A then B over a shared
// bus, steps subtractions from the comparator flags, and holds done/err until acknowledged.
module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ack,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             ldA,
    output logic             ldB,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDB,
        S_CMP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_count_q, iter_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            iter_count_q <= '0;
        end else begin
            state_q      <= state_d;
            iter_count_q <= iter_count_d;
        end
    end

    // Loads are qualified with rst_n so nothing is written while reset is asserted.
    always_comb begin
        state_d      = state_q;
        iter_count_d = iter_count_q;
        in_ready     = 1'b0;
        sel1         = 1'b0;
        sel2         = 1'b0;
        sel_in       = 1'b0;
        ldA          = 1'b0;
        ldB          = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        busy         = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && rst_n) begin
                    ldA          = 1'b1;
                    iter_count_d = '0;
                    state_d      = S_LDB;
                end
            end
            S_LDB: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && rst_n) begin
                    ldB     = 1'b1;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                busy   = 1'b1;
                sel_in = 1'b1;
                if (eq) begin
                    state_d = S_DONE;
                end else if (gt || lt) begin
                    // The watchdog aborts before the step that would pass MAX_ITER.
                    if (iter_count_q >= MAX_CNT) begin
                        state_d = S_ERR;
                    end else begin
                        iter_count_d = iter_count_q + 1'b1;
                        if (gt) begin
                            sel1 = 1'b1;
                            ldA  = rst_n;
                        end else begin
                            sel2 = 1'b1;
                            ldB  = rst_n;
                        end
                    end
                end else begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
                if (out_ack) state_d = S_IDLE;
            end
            S_ERR: begin
                err  = 1'b1;
                busy = 1'b1;
                if (out_ack) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iter_count = iter_count_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed plus randomized bench for gcd_controller, with a behavioural datapath around
// the controller and an arithmetic Euclid reference model for result and step count.
module tb_gcd_controller;

    localparam int MAX_ITER = 40;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             out_ack;
    logic             lt, gt, eq;
    logic             sel1, sel2, sel_in, ldA, ldB;
    logic             done, err, busy;
    logic [CNT_W-1:0] iter_count;

    logic [15:0] data_in;
    logic [15:0] a_reg, b_reg, sub_val, bus_val;
    logic        force_en, f_lt, f_gt, f_eq;

    int compared   = 0;
    int mismatched = 0;

    gcd_controller #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ack    (out_ack),
        .lt         (lt),
        .gt         (gt),
        .eq         (eq),
        .sel1       (sel1),
        .sel2       (sel2),
        .sel_in     (sel_in),
        .ldA        (ldA),
        .ldB        (ldB),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    // Environment datapath: muxes, subtractor, A/B registers and comparator.
    assign sub_val = (sel1 ? a_reg : b_reg) - (sel2 ? a_reg : b_reg);
    assign bus_val = sel_in ? sub_val : data_in;
    assign lt      = force_en ? f_lt : (a_reg < b_reg);
    assign gt      = force_en ? f_gt : (a_reg > b_reg);
    assign eq      = force_en ? f_eq : (a_reg == b_reg);

    always @(posedge clk) begin
        if (ldA) a_reg <= bus_val;
        if (ldB) b_reg <= bus_val;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: repeated subtraction, aborting when another step would exceed MAX_ITER.
    task automatic ref_gcd(input int a, input int b, output int res, output int steps, output bit is_err);
        steps  = 0;
        is_err = 1'b0;
        forever begin
            if (a == b) break;
            if (steps == MAX_ITER) begin
                is_err = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            steps++;
        end
        res = a;
    endtask

    task automatic apply_stimulus(input int a, input int b, input int gap);
        check_output("idle_ready", {31'b0, in_ready}, 1);
        check_output("idle_busy", {31'b0, busy}, 0);
        data_in  = 16'(a);
        in_valid = 1'b1;
        #1;
        check_output("ldA_on_valid", {31'b0, ldA}, 1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check_output("ldb_busy", {31'b0, busy}, 1);
        check_output("ldb_ready", {31'b0, in_ready}, 1);
        for (int i = 0; i < gap; i++) begin
            next_cycle();
            check_output("ldb_hold_ldB", {31'b0, ldB}, 0);
            check_output("ldb_hold_busy", {31'b0, busy}, 1);
        end
        data_in  = 16'(b);
        in_valid = 1'b1;
        #1;
        check_output("ldB_on_valid", {31'b0, ldB}, 1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic ack_out(input int delay, input bit pulse_valid);
        for (int i = 0; i < delay; i++) begin
            if (pulse_valid) begin
                in_valid = 1'b1;
                #1;
                check_output("done_ignores_valid", {31'b0, ldA}, 0);
                check_output("done_not_ready", {31'b0, in_ready}, 0);
            end
            next_cycle();
            in_valid = 1'b0;
        end
        out_ack = 1'b1;
        next_cycle();
        out_ack = 1'b0;
        #1;
        check_output("ack_idle_busy", {31'b0, busy}, 0);
        check_output("ack_idle_ready", {31'b0, in_ready}, 1);
        check_output("ack_done_clear", {31'b0, done}, 0);
        check_output("ack_err_clear", {31'b0, err}, 0);
    endtask

    task automatic run_op(input int a, input int b, input int gap, input int ack_delay, input bit pulse_valid);
        int res, steps, cycles;
        bit is_err;
        ref_gcd(a, b, res, steps, is_err);
        apply_stimulus(a, b, gap);
        cycles = 0;
        while (!(done || err) && cycles < MAX_ITER + 10) begin
            next_cycle();
            cycles++;
        end
        check_output($sformatf("latency(%0d,%0d)", a, b), 32'(cycles), 32'(steps + 1));
        check_output($sformatf("done(%0d,%0d)", a, b), {31'b0, done}, {31'b0, !is_err});
        check_output($sformatf("err(%0d,%0d)", a, b), {31'b0, err}, {31'b0, is_err});
        check_output($sformatf("iter(%0d,%0d)", a, b), 32'(iter_count), 32'(steps));
        if (!is_err) check_output($sformatf("result(%0d,%0d)", a, b), 32'(a_reg), 32'(res));
        ack_out(ack_delay, pulse_valid);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        out_ack  = 1'b0;
        data_in  = '0;
        force_en = 1'b0;
        f_lt     = 1'b0;
        f_gt     = 1'b0;
        f_eq     = 1'b0;
        #3;
        check_output("rst_ldA", {31'b0, ldA}, 0);
        check_output("rst_ready", {31'b0, in_ready}, 1);
        check_output("rst_busy", {31'b0, busy}, 0);
        check_output("rst_iter", 32'(iter_count), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        run_op(48, 18, 0, 2, 1'b0);
        run_op(7, 7, 0, 3, 1'b1);
        run_op(5, 0, 0, 1, 1'b0);
        run_op(0, 0, 0, 0, 1'b0);
        run_op(30, 12, 10, 0, 1'b0);

        // Asynchronous reset in the middle of a long subtraction run.
        apply_stimulus(100, 3, 0);
        repeat (5) next_cycle();
        check_output("mid_cmp_busy", {31'b0, busy}, 1);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_output("arst_ldA", {31'b0, ldA}, 0);
        check_output("arst_ldB", {31'b0, ldB}, 0);
        check_output("arst_sel", {29'b0, sel1, sel2, sel_in}, 0);
        check_output("arst_busy", {31'b0, busy}, 0);
        check_output("arst_ready", {31'b0, in_ready}, 1);
        check_output("arst_iter", 32'(iter_count), 0);
        next_cycle();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        next_cycle();
        run_op(21, 14, 0, 1, 1'b0);

        // Illegal flags: none set.
        apply_stimulus(9, 4, 0);
        force_en = 1'b1;
        {f_lt, f_gt, f_eq} = 3'b000;
        #1;
        check_output("noflag_noload", {30'b0, ldA, ldB}, 0);
        next_cycle();
        check_output("noflag_err", {31'b0, err}, 1);
        check_output("noflag_done", {31'b0, done}, 0);
        force_en = 1'b0;
        ack_out(0, 1'b0);

        // eq takes priority over gt.
        apply_stimulus(9, 4, 0);
        force_en = 1'b1;
        {f_lt, f_gt, f_eq} = 3'b011;
        #1;
        check_output("eqgt_noload", {30'b0, ldA, ldB}, 0);
        next_cycle();
        check_output("eqgt_done", {31'b0, done}, 1);
        check_output("eqgt_err", {31'b0, err}, 0);
        force_en = 1'b0;
        ack_out(0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_op(int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
